// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller states, round count, Rcon and S-box lookups.
package aes_pkg;

    localparam int NROUNDS = 10;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } state_t;

    // Byte n of the table lives at bits [8*(255-n)+7 -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] rc;
        case (idx)
            4'd0:    rc = 8'h01;
            4'd1:    rc = 8'h02;
            4'd2:    rc = 8'h04;
            4'd3:    rc = 8'h08;
            4'd4:    rc = 8'h10;
            4'd5:    rc = 8'h20;
            4'd6:    rc = 8'h40;
            4'd7:    rc = 8'h80;
            4'd8:    rc = 8'h1b;
            4'd9:    rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (skipped on the final round), AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] i_state,
    input  logic [127:0] i_round_key,
    input  logic         i_final,
    output logic [127:0] o_state
);

    logic [127:0] w_sub;
    logic [127:0] w_shift;
    logic [127:0] w_mix;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] s0, s1, s2, s3;
        s0 = col[31:24];
        s1 = col[23:16];
        s2 = col[15:8];
        s3 = col[7:0];
        return {xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3,
                s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3,
                s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3,
                xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3)};
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign w_sub[127-8*i -: 8] = sbox(i_state[127-8*i -: 8]);
    end

    shiftrow u_shiftrow (
        .i_state (w_sub),
        .o_state (w_shift)
    );

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign w_mix[127-32*c -: 32] = mix_col(w_shift[127-32*c -: 32]);
    end

    assign o_state = (i_final ? w_shift : w_mix) ^ i_round_key;

endmodule

// File: rtl/shiftrow.sv
// AES ShiftRows: row r of the column-major state rotates left by r byte positions.
module shiftrow (
    input  logic [127:0] i_state,
    output logic [127:0] o_state
);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign o_state[127-8*(r+4*c) -: 8] = i_state[127-8*(r+4*((c+r)%4)) -: 8];
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly from a single key register.
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         busy,
    output logic         done,
    output logic [127:0] ciphertext,
    output logic [3:0]   round_idx
);

    state_t       r_fsm;
    state_t       w_fsm_nxt;
    logic [127:0] r_state;
    logic [127:0] r_key;
    logic [127:0] r_ct;
    logic [3:0]   r_round_idx;
    logic [127:0] w_round_out;
    logic [127:0] w_next_key;
    logic         w_final;

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    assign w_final    = (r_fsm == FINAL);
    assign w_next_key = key_step(r_key, rcon(r_round_idx));

    aes_round u_round (
        .i_state     (r_state),
        .i_round_key (r_key),
        .i_final     (w_final),
        .o_state     (w_round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt = r_fsm;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (start) w_fsm_nxt = INIT;
            end
            INIT: begin
                busy      = 1'b1;
                w_fsm_nxt = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (r_round_idx == 4'(NROUNDS - 1)) w_fsm_nxt = FINAL;
            end
            FINAL: begin
                busy      = 1'b1;
                w_fsm_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                w_fsm_nxt = start ? INIT : IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // The key register always holds the round key consumed by the next round evaluation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= '0;
            r_key       <= '0;
            r_ct        <= '0;
            r_round_idx <= '0;
        end else begin
            case (r_fsm)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= plaintext;
                        r_key       <= key;
                        r_round_idx <= 4'd0;
                    end
                end
                INIT: begin
                    r_state     <= r_state ^ r_key;
                    r_key       <= w_next_key;
                    r_round_idx <= 4'd1;
                end
                ROUND: begin
                    r_state     <= w_round_out;
                    r_key       <= w_next_key;
                    r_round_idx <= r_round_idx + 4'd1;
                end
                FINAL: begin
                    r_ct <= w_round_out;
                end
                default: begin
                end
            endcase
        end
    end

    assign ciphertext = r_ct;
    assign round_idx  = r_round_idx;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: known-answer and random AES-128 blocks against a behavioural model.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic [3:0]   round_idx;

    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] last_ct;
    logic [7:0]   sb [256];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext),
        .round_idx  (round_idx)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box derived from first principles: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int rr = 0; rr < 4; rr++) a[rr] = s[4*c+rr];
                    for (int rr = 0; rr < 4; rr++)
                        s[4*c+rr] = gmul(a[rr], 8'h02) ^ gmul(a[(rr+1)%4], 8'h03) ^ a[(rr+2)%4] ^ a[(rr+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One encryption from IDLE; optional start pulses with fresh data while busy.
    task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] exp_ct, input bit glitch);
        int          n_done;
        int          done_edge;
        int          busy_cyc;
        logic [43:0] trace;
        logic [43:0] trace_exp;
        n_done    = 0;
        done_edge = -1;
        busy_cyc  = 0;
        trace     = '0;
        trace_exp = '0;
        start     = 1'b1;
        plaintext = pt;
        key       = k;
        tick();
        for (int e = 0; e <= 15; e++) begin
            if (e > 0) tick();
            start = 1'b0;
            if (e <= 10) begin
                trace     = {trace[39:0], round_idx};
                trace_exp = {trace_exp[39:0], 4'(e)};
            end
            if (busy) busy_cyc++;
            if (done) begin
                n_done++;
                if (done_edge < 0) done_edge = e;
            end
            if (e == 10) check({tag, "/ct_hold"}, ciphertext, last_ct);
            if (glitch && (e == 3 || e == 7)) begin
                start     = 1'b1;
                plaintext = rnd128();
                key       = rnd128();
            end
        end
        check({tag, "/ct"}, ciphertext, exp_ct);
        check({tag, "/latency"}, 128'(done_edge + 1), 128'd12);
        check({tag, "/done_cnt"}, 128'(n_done), 128'd1);
        check({tag, "/busy_cyc"}, 128'(busy_cyc), 128'd11);
        check({tag, "/idx_trace"}, 128'(trace), 128'(trace_exp));
        last_ct = exp_ct;
    endtask

    task automatic run_b2b(input logic [127:0] pa, input logic [127:0] ka, input logic [127:0] ea,
                           input logic [127:0] pb, input logic [127:0] kb, input logic [127:0] eb);
        int d1;
        int d2;
        int n_done;
        bit stable;
        d1     = -1;
        d2     = -1;
        n_done = 0;
        stable = 1'b1;
        start     = 1'b1;
        plaintext = pa;
        key       = ka;
        tick();
        for (int e = 1; e <= 28; e++) begin
            tick();
            if (done) begin
                n_done++;
                if (d1 < 0) d1 = e;
                else if (d2 < 0) d2 = e;
            end
            if (e == 11) begin
                check("b2b/ct_a", ciphertext, ea);
                plaintext = pb;
                key       = kb;
            end
            if (e == 12) start = 1'b0;
            if (e > 11 && e < 23 && ciphertext !== ea) stable = 1'b0;
        end
        check("b2b/ct_b", ciphertext, eb);
        check("b2b/done_cnt", 128'(n_done), 128'd2);
        check("b2b/first_done", 128'(d1 + 1), 128'd12);
        check("b2b/spacing", 128'(d2 - d1), 128'd12);
        check("b2b/ct_stable", 128'(stable), 128'd1);
        last_ct = eb;
    endtask

    task automatic run_reset_abort(input logic [127:0] pt, input logic [127:0] k);
        int n_done;
        int guard;
        n_done    = 0;
        guard     = 0;
        start     = 1'b1;
        plaintext = pt;
        key       = k;
        tick();
        start = 1'b0;
        while (round_idx != 4'd5 && guard < 20) begin
            tick();
            guard++;
        end
        check("rst/reach_idx5", 128'(round_idx), 128'd5);
        rst = 1'b1;
        #1;
        check("rst/busy", 128'(busy), 128'd0);
        check("rst/done", 128'(done), 128'd0);
        check("rst/ct", ciphertext, 128'd0);
        check("rst/round_idx", 128'(round_idx), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 14; e++) begin
            tick();
            if (done) n_done++;
        end
        check("rst/no_done", 128'(n_done), 128'd0);
        last_ct = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] rp;
        logic [127:0] rk;
        rst       = 1'b1;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;
        last_ct   = '0;
        build_sbox();
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", 128'(busy), 128'd0);
        check("reset/done", 128'(done), 128'd0);
        check("reset/round_idx", 128'(round_idx), 128'd0);
        check("reset/ct", ciphertext, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_block("kat1", P1, K1, C1, 1'b0);
        run_block("kat2", P2, K2, C2, 1'b0);
        run_block("busy_start", P1, K1, C1, 1'b1);
        run_b2b(P2, K2, C2, P1, K1, C1);
        for (int n = 0; n < 6; n++) begin
            rp = rnd128();
            rk = rnd128();
            run_block("rand", rp, rk, aes_ref(rp, rk), 1'($urandom_range(0, 1)));
        end
        run_reset_abort(P1, K1);
        run_block("after_rst", P2, K2, C2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
